control_loop_sequencer: RTL and testbench
=========================================

// Module: control_loop_sequencer
// PURPOSE
//  Sequences one temperature-control iteration per sample period:
//  AD conversion -> control-core step -> DA/PWM level update.
//  Sits between AD front end, PID/simple cores and DA/PWM output.
//  Owns the held output level and resynchronises the cores on enable/setpoint changes.
// PARAMETERS
//  PERIOD   1000  clock cycles between loop starts (>=8)
//  LEVEL_W  8     width of temperature / output level
//  TIMEOUT  255   max cycles in any wait state (used only with LOOP_TIMEOUT_EN)
// PORTS
//  clock       in   1        single system clock, rising edge
//  reset       in   1        asynchronous, active-high
//  enable      in   1        power/run; low = loop idle, output 0
//  destChanged in   1        setpoint changed; abort iteration, clear cores
//  adStart     out  1        1-cycle request for AD conversion
//  adDone      in   1        1-cycle strobe: adLevel is valid
//  adLevel     in   LEVEL_W  converted temperature
//  sample      out  LEVEL_W  last latched temperature, to cores/displays
//  coreStep    out  1        1-cycle strobe: core computes from sample
//  coreValid   in   1        1-cycle strobe: coreLevel is valid
//  coreLevel   in   LEVEL_W  selected core output level
//  coreClear   out  1        1-cycle core resynchronise pulse
//  daStart     out  1        1-cycle request to write daLevel
//  daDone      in   1        1-cycle strobe: DA write complete
//  daLevel     out  LEVEL_W  held output level to DA and PWM
//  busy        out  1        high whenever state != IDLE
//  overrun     out  1        sticky: period tick while busy
//  fault       out  1        sticky timeout flag (0 without LOOP_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, period counter 0.
//  Period counter 0..PERIOD-1 while enable; tick when count==PERIOD-1; held at 0 while !enable.
//  States: IDLE, AD_REQ, AD_WAIT, CORE_REQ, CORE_WAIT, DA_REQ, DA_WAIT.
//  IDLE    -> AD_REQ on tick. AD_REQ: adStart=1 for one cycle -> AD_WAIT.
//  AD_WAIT -> CORE_REQ on adDone; sample<=adLevel on that edge.
//  CORE_REQ: coreStep=1 for one cycle -> CORE_WAIT.
//  CORE_WAIT -> DA_REQ on coreValid; daLevel<=coreLevel on that edge.
//  DA_REQ: daStart=1 for one cycle -> DA_WAIT. DA_WAIT -> IDLE on daDone.
//  Latency: tick@T -> adStart@T+1; adDone@A -> coreStep@A+1; coreValid@C -> daStart@C+1.
//  Strobes arriving outside their wait state are ignored.
//  Tick while busy: iteration continues, tick dropped, overrun<=1.
//  Priority: !enable > destChanged > timeout > normal transitions.
//  !enable: next edge -> IDLE, daLevel<=0, overrun/fault cleared; no pulses issued.
//  destChanged (enable high): next edge -> IDLE, coreClear=1 one cycle,
//   daLevel held, period counter restarts at 0. Held high = coreClear each cycle, loop stalls.
//  At most one of adStart/coreStep/daStart/coreClear high in any cycle.
// CONFIGURATION
//  LOOP_TIMEOUT_EN defined: per-wait counter reset on entering any wait state;
//   TIMEOUT cycles without the awaited strobe -> IDLE, fault<=1, daLevel<=0.
//   fault is sticky until reset or !enable; loop keeps running on later ticks.
//  Undefined: waits unbounded, fault tied 0, no timeout counter.
// STRUCTURE
//  Shared package tc_pkg: state encodings as localparams, LEVEL_W default,
//   strobe/level width constants shared with AD, DA and the cores.
//  Sub-module loop_period_timer: period counter + tick, with enable and restart inputs.
// TESTING
//  PERIOD=16, AD/core/DA responders 2 cycles each -> daStart 1 cycle after coreValid,
//   daLevel=coreLevel (0x5A), one iteration per 16 cycles, overrun=0.
//  DA responder delays daDone 20 cycles -> overrun=1 at next tick, iteration completes.
//  destChanged in CORE_WAIT -> IDLE, coreClear single pulse, daLevel keeps 0x5A,
//   late coreValid ignored.
//  enable low mid-AD_WAIT -> IDLE next edge, daLevel=0, no adStart while low.
//  LOOP_TIMEOUT_EN, TIMEOUT=10, adDone withheld -> fault=1 after 10 cycles,
//   daLevel=0, next tick restarts with adStart.
//  reset asserted mid-DA_WAIT -> all outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared constants for the temperature-control loop: sequencer state encodings
// and the default level width used by the AD front end, the cores and the DA/PWM output.
package tc_pkg;

    localparam int unsigned LEVEL_W_DEF = 8;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_AD_REQ    = 3'd1;
    localparam logic [STATE_W-1:0] ST_AD_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CORE_REQ  = 3'd3;
    localparam logic [STATE_W-1:0] ST_CORE_WAIT = 3'd4;
    localparam logic [STATE_W-1:0] ST_DA_REQ    = 3'd5;
    localparam logic [STATE_W-1:0] ST_DA_WAIT   = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = ST_IDLE,
        S_AD_REQ    = ST_AD_REQ,
        S_AD_WAIT   = ST_AD_WAIT,
        S_CORE_REQ  = ST_CORE_REQ,
        S_CORE_WAIT = ST_CORE_WAIT,
        S_DA_REQ    = ST_DA_REQ,
        S_DA_WAIT   = ST_DA_WAIT
    } loop_state_e;

    function automatic logic is_wait(input loop_state_e s);
        return (s == S_AD_WAIT) || (s == S_CORE_WAIT) || (s == S_DA_WAIT);
    endfunction

endpackage

// File: rtl/loop_period_timer.sv
// Sample-period counter: counts 0..PERIOD-1 while enabled and flags the last count
// with a registered tick; held at 0 while disabled, restarted to 0 on request.
module loop_period_timer #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable_i || restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // tick_q is high exactly in the cycles where the count sits at PERIOD-1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/control_loop_sequencer.sv
// Sequences one AD -> core step -> DA update per sample period and owns the held output level.
// Optional wait-state timeout guarded by `LOOP_TIMEOUT_EN (adds TIMEOUT parameter and fault flag).
module control_loop_sequencer
    import tc_pkg::*;
#(
    parameter int unsigned PERIOD  = 1000,
`ifdef LOOP_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 255,
`endif
    parameter int unsigned LEVEL_W = LEVEL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               dest_changed_i,
    output logic               ad_start_o,
    input  logic               ad_done_i,
    input  logic [LEVEL_W-1:0] ad_level_i,
    output logic [LEVEL_W-1:0] sample_o,
    output logic               core_step_o,
    input  logic               core_valid_i,
    input  logic [LEVEL_W-1:0] core_level_i,
    output logic               core_clear_o,
    output logic               da_start_o,
    input  logic               da_done_i,
    output logic [LEVEL_W-1:0] da_level_o,
    output logic               busy_o,
    output logic               overrun_o,
    output logic               fault_o
);

    loop_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] sample_q, sample_d;
    logic [LEVEL_W-1:0] da_level_q, da_level_d;
    logic               overrun_q, overrun_d;
    logic               fault_q, fault_d;
    logic               ad_start_q, core_step_q, da_start_q, core_clear_q, busy_q;
    logic               clear_d;
    logic               tick;
    logic               restart;
    logic               timeout_c;

    assign restart = enable_i && dest_changed_i;

    loop_period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .restart_i(restart),
        .tick_o   (tick)
    );

`ifdef LOOP_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            awaited;

    // Wait counter restarts on every state change, so each wait state gets a fresh budget
    always_comb begin
        awaited = 1'b0;
        case (state_q)
            S_AD_WAIT:   awaited = ad_done_i;
            S_CORE_WAIT: awaited = core_valid_i;
            S_DA_WAIT:   awaited = da_done_i;
            default:     awaited = 1'b0;
        endcase
        timeout_c  = is_wait(state_q) && (wait_cnt_q == TO_W'(TIMEOUT - 1)) && !awaited;
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (is_wait(state_q)) begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next state: disable beats setpoint change beats timeout beats normal flow
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        da_level_d = da_level_q;
        overrun_d  = overrun_q;
        fault_d    = fault_q;
        clear_d    = 1'b0;

        if (!enable_i) begin
            state_d    = S_IDLE;
            da_level_d = '0;
            overrun_d  = 1'b0;
            fault_d    = 1'b0;
        end else if (dest_changed_i) begin
            state_d = S_IDLE;
            clear_d = 1'b1;
        end else if (timeout_c) begin
            state_d    = S_IDLE;
            fault_d    = 1'b1;
            da_level_d = '0;
        end else begin
            if (tick && (state_q != S_IDLE)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                S_IDLE:     if (tick) state_d = S_AD_REQ;
                S_AD_REQ:   state_d = S_AD_WAIT;
                S_AD_WAIT: begin
                    if (ad_done_i) begin
                        state_d  = S_CORE_REQ;
                        sample_d = ad_level_i;
                    end
                end
                S_CORE_REQ: state_d = S_CORE_WAIT;
                S_CORE_WAIT: begin
                    if (core_valid_i) begin
                        state_d    = S_DA_REQ;
                        da_level_d = core_level_i;
                    end
                end
                S_DA_REQ:   state_d = S_DA_WAIT;
                S_DA_WAIT:  if (da_done_i) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so each one lines up with its REQ state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            sample_q     <= '0;
            da_level_q   <= '0;
            overrun_q    <= 1'b0;
            fault_q      <= 1'b0;
            ad_start_q   <= 1'b0;
            core_step_q  <= 1'b0;
            da_start_q   <= 1'b0;
            core_clear_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            da_level_q   <= da_level_d;
            overrun_q    <= overrun_d;
            fault_q      <= fault_d;
            ad_start_q   <= (state_d == S_AD_REQ);
            core_step_q  <= (state_d == S_CORE_REQ);
            da_start_q   <= (state_d == S_DA_REQ);
            core_clear_q <= clear_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign ad_start_o   = ad_start_q;
    assign core_step_o  = core_step_q;
    assign da_start_o   = da_start_q;
    assign core_clear_o = core_clear_q;
    assign sample_o     = sample_q;
    assign da_level_o   = da_level_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_control_loop_sequencer.sv
// Directed bench for control_loop_sequencer with AD/core/DA responders (PERIOD=16).
// Build with LOOP_TIMEOUT_EN defined to also exercise the wait-state timeout (TIMEOUT=10).
module tb_control_loop_sequencer;

    localparam int unsigned PERIOD  = 16;
    localparam int unsigned LEVEL_W = 8;
`ifdef LOOP_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 10;
    localparam int DA_LONG = 10;
`else
    localparam int DA_LONG = 20;
`endif

    logic               clk, rst, enable, dest_changed;
    logic               ad_start, ad_done, core_step, core_valid, core_clear;
    logic               da_start, da_done, busy, overrun, fault;
    logic [LEVEL_W-1:0] ad_level, sample, core_level, da_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int ad_dly = 2, core_dly = 2, da_dly = 2;
    int ad_cnt = 0, core_cnt = 0, da_cnt = 0;
    bit ad_en = 1'b1;

    control_loop_sequencer #(
        .PERIOD (PERIOD),
`ifdef LOOP_TIMEOUT_EN
        .TIMEOUT(TIMEOUT),
`endif
        .LEVEL_W(LEVEL_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .dest_changed_i(dest_changed),
        .ad_start_o    (ad_start),
        .ad_done_i     (ad_done),
        .ad_level_i    (ad_level),
        .sample_o      (sample),
        .core_step_o   (core_step),
        .core_valid_i  (core_valid),
        .core_level_i  (core_level),
        .core_clear_o  (core_clear),
        .da_start_o    (da_start),
        .da_done_i     (da_done),
        .da_level_o    (da_level),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .fault_o       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Responders: strobe comes back dly cycles after the request; also check strobe exclusivity
    always @(negedge clk) begin
        ad_done    = 1'b0;
        core_valid = 1'b0;
        da_done    = 1'b0;
        if (ad_cnt > 0) begin ad_cnt--; if (ad_cnt == 0) ad_done = 1'b1; end
        if (core_cnt > 0) begin core_cnt--; if (core_cnt == 0) core_valid = 1'b1; end
        if (da_cnt > 0) begin da_cnt--; if (da_cnt == 0) da_done = 1'b1; end
        if (ad_start && ad_en) ad_cnt = ad_dly;
        if (core_step) core_cnt = core_dly;
        if (da_start) da_cnt = da_dly;
        if (!rst) check("strobe_excl", 32'($countones({ad_start, core_step, da_start, core_clear}) <= 1), 1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ad_start"}, ad_start, 0);
        check({tag, "_core_step"}, core_step, 0);
        check({tag, "_da_start"}, da_start, 0);
        check({tag, "_core_clear"}, core_clear, 0);
        check({tag, "_sample"}, sample, 0);
        check({tag, "_da_level"}, da_level, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_fault"}, fault, 0);
    endtask

    initial begin
        int a, b, c, d, e, f, g, h, n;
        rst = 1'b1; enable = 1'b0; dest_changed = 1'b0;
        ad_level = 8'h33; core_level = 8'h5A;
        ad_done = 1'b0; core_valid = 1'b0; da_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0; enable = 1'b1;

        // Normal iteration
        a = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ad_start) begin a = cyc; break; end
        end
        check("first_ad_start_seen", 32'(a >= 0), 1);
        if (a < 0) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "no adStart within bound");
        end
        wait_to(a + 1);  check("ad_start_one_cycle", ad_start, 0); check("busy_ad", busy, 1);
        wait_to(a + 3);  check("core_step", core_step, 1); check("sample", sample, 8'h33);
        wait_to(a + 4);  check("core_step_one_cycle", core_step, 0);
        wait_to(a + 6);  check("da_start", da_start, 1); check("da_level", da_level, 8'h5A);
        wait_to(a + 8);  check("busy_da_wait", busy, 1);
        wait_to(a + 9);  check("idle_after_da", busy, 0); check("no_overrun", overrun, 0);
        da_dly = DA_LONG;
        wait_to(a + 15); check("no_early_ad_start", ad_start, 0);
        wait_to(a + 16); check("period_ad_start", ad_start, 1);
        b = a + 16;

        // Slow DA: tick while busy sets overrun, iteration still completes
        wait_to(b + 15);           check("overrun_before_tick", overrun, 0);
        wait_to(b + 16);           check("overrun_set", overrun, 1); check("tick_dropped", ad_start, 0);
        wait_to(b + 6 + DA_LONG);  check("busy_long_da", busy, 1);
        wait_to(b + 7 + DA_LONG);  check("long_da_done", busy, 0); check("no_fault_long_da", fault, 0);
        da_dly = 2; core_dly = 6;
        wait_to(b + 32);           check("ad_start_after_overrun", ad_start, 1);
        c = b + 32;

        // Setpoint change in CORE_WAIT
        wait_to(c + 5);  dest_changed = 1'b1; core_level = 8'hA5;
        wait_to(c + 6);  dest_changed = 1'b0;
        check("core_clear", core_clear, 1); check("dest_idle", busy, 0); check("dest_da_held", da_level, 8'h5A);
        wait_to(c + 7);  check("core_clear_single", core_clear, 0); check("overrun_sticky", overrun, 1);
        wait_to(c + 10); check("late_core_ignored", da_level, 8'h5A); check("late_no_da_start", da_start, 0);
        check("late_still_idle", busy, 0);
        core_level = 8'h5A; core_dly = 2;
        wait_to(c + 21); check("restart_no_early", ad_start, 0);
        wait_to(c + 22); check("restart_ad_start", ad_start, 1);
        d = c + 22;

        // Enable low during AD_WAIT
        wait_to(d + 1);  enable = 1'b0; ad_level = 8'h44;
        wait_to(d + 2);  check("dis_idle", busy, 0); check("dis_da_level", da_level, 0);
        check("dis_overrun_clr", overrun, 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ad_start || core_step || da_start || core_clear) n++;
        end
        check("dis_no_pulses", n, 0); check("dis_sample_held", sample, 8'h33);
        e = cyc; enable = 1'b1;
        wait_to(e + 15); check("reen_no_early", ad_start, 0);
        wait_to(e + 16); check("reen_ad_start", ad_start, 1);
        f = e + 16;
        wait_to(f + 3);  check("reen_sample", sample, 8'h44);
        wait_to(f + 6);  check("reen_da_level", da_level, 8'h5A);

        g = f + 16;
`ifdef LOOP_TIMEOUT_EN
        // AD never answers: timeout after TIMEOUT wait cycles
        wait_to(f + 10); ad_en = 1'b0;
        wait_to(g);      check("to_ad_start", ad_start, 1);
        wait_to(g + 10); check("to_fault_pending", fault, 0); check("to_busy", busy, 1);
        wait_to(g + 11); check("to_fault", fault, 1); check("to_idle", busy, 0); check("to_da_zero", da_level, 0);
        ad_en = 1'b1;
`else
        wait_to(g);      check("g_ad_start", ad_start, 1);
        wait_to(g + 11); check("fault_tied_zero", fault, 0); check("g_da_level", da_level, 8'h5A);
`endif
        h = g + 16;
        wait_to(h);      check("h_ad_start", ad_start, 1);
        da_dly = 20;

        // Asynchronous reset in DA_WAIT
        wait_to(h + 8);  check("h_busy", busy, 1); check("h_da_level", da_level, 8'h5A);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
